// File: rtl/fnd_pkg.sv
//------------------------------------------------------------------------------
// Module   : fnd_pkg
// Brief    : Shared types and constants for the FND scan controller slice.
//            Optional build macro used by the slice: FND_LEADING_ZERO_BLANK_EN
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fnd_pkg;

   // Conversion sequencer states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } fsm_state_t;

   // Code the downstream decoder renders as all segments off
   localparam logic [3:0] BLANK_CODE = 4'hF;

   // Default geometry of the display
   localparam int DEF_DIGITS      = 4;
   localparam int DEF_BIN_W       = 14;
   localparam int DEF_REFRESH_DIV = 50000;

endpackage

`default_nettype wire

// File: rtl/fnd_scan_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : fnd_scan_ctrl_if
// Brief    : Value handshake and digit-drive bundle of the FND scan controller.
//            master = value producer / display sink, slave = fnd_scan_ctrl.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface fnd_scan_ctrl_if
   import fnd_pkg::*;
#(
   parameter int BIN_W  = DEF_BIN_W,
   parameter int DIGITS = DEF_DIGITS
);

   logic              i_valid;
   logic [BIN_W-1:0]  i_bin;
   logic              o_ready;
   logic              o_done;
   logic              o_ovf;
   logic [3:0]        o_digit_data;
   logic [DIGITS-1:0] o_com;

   modport master (
      output i_valid,
      output i_bin,
      input  o_ready,
      input  o_done,
      input  o_ovf,
      input  o_digit_data,
      input  o_com
   );

   modport slave (
      input  i_valid,
      input  i_bin,
      output o_ready,
      output o_done,
      output o_ovf,
      output o_digit_data,
      output o_com
   );

endinterface

`default_nettype wire

// File: rtl/fnd_scan_ctrl_bin2bcd_serial.sv
//------------------------------------------------------------------------------
// Module   : bin2bcd_serial
// Brief    : Serial double-dabble binary to BCD converter, one bit per clock.
//            o_done is high during the cycle whose closing edge performs the
//            final shift, so o_bcd holds the result from the next cycle on.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bin2bcd_serial
   import fnd_pkg::*;
#(
   parameter int BIN_W  = DEF_BIN_W,
   parameter int DIGITS = DEF_DIGITS
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_start,
   input  logic [BIN_W-1:0]      i_bin,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [4*DIGITS-1:0]   o_bcd
);

   localparam int                 c_cnt_w = (BIN_W > 1) ? $clog2(BIN_W) : 1;
   localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(BIN_W - 1);

   logic [BIN_W-1:0]    r_bin;
   logic [4*DIGITS-1:0] r_bcd;
   logic [4*DIGITS-1:0] w_bcd_adj;
   logic [c_cnt_w-1:0]  r_cnt;
   logic                r_busy;

   // Add-3 correction: a nibble of 5..9 becomes 8..12, which still fits 4 bits
   generate
      for (genvar g = 0; g < DIGITS; g++) begin : g_adj
         assign w_bcd_adj[4*g +: 4] = (r_bcd[4*g +: 4] >= 4'd5) ?
                                      (r_bcd[4*g +: 4] + 4'd3) : r_bcd[4*g +: 4];
      end
   endgenerate

   // Load on start, then shift {bcd, bin} left once per clock for BIN_W clocks
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_bin  <= '0;
         r_bcd  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
      end else if (i_start && !r_busy) begin
         r_bin  <= i_bin;
         r_bcd  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b1;
      end else if (r_busy) begin
         {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
         r_cnt          <= r_cnt + 1'b1;
         if (r_cnt == c_last) begin
            r_busy <= 1'b0;
         end
      end
   end

   assign o_busy = r_busy;
   assign o_done = r_busy && (r_cnt == c_last);
   assign o_bcd  = r_bcd;

endmodule

`default_nettype wire

// File: rtl/fnd_scan_ctrl.sv
//------------------------------------------------------------------------------
// Module   : fnd_scan_ctrl
// Brief    : Accepts a binary value, converts it to BCD and time-multiplexes
//            the digits onto a 4-bit decoder bus with active-low commons.
//            Build macro FND_LEADING_ZERO_BLANK_EN: blank leading zero digits.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fnd_scan_ctrl
   import fnd_pkg::*;
#(
   parameter int BIN_W       = DEF_BIN_W,
   parameter int DIGITS      = DEF_DIGITS,
   parameter int REFRESH_DIV = DEF_REFRESH_DIV
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   fnd_scan_ctrl_if.slave  bus
);

   localparam logic [63:0] c_limit   = 64'(10 ** DIGITS);
   localparam logic [63:0] c_max     = c_limit - 64'd1;
   localparam int          c_idx_w   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int          c_presc_w = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [c_idx_w-1:0]   c_last_idx   = c_idx_w'(DIGITS - 1);
   localparam logic [c_presc_w-1:0] c_last_presc = c_presc_w'(REFRESH_DIV - 1);

   fsm_state_t                r_state;
   logic                      r_ready;
   logic                      r_done;
   logic                      r_ovf;
   logic [DIGITS-1:0][3:0]    r_disp;

   logic [c_presc_w-1:0]      r_presc;
   logic [c_idx_w-1:0]        r_idx;
   logic [DIGITS-1:0]         r_com;
   logic [3:0]                r_digit_data;

   logic                      w_accept;
   logic                      w_clamp;
   logic [BIN_W-1:0]          w_bin_cap;
   logic                      w_cvt_busy;
   logic                      w_cvt_last;
   logic [4*DIGITS-1:0]       w_bcd;
   logic                      w_wrap;
   logic [c_idx_w-1:0]        w_idx_nxt;
   logic [DIGITS-1:0][3:0]    w_code;

   // Clamp compares at full input width; only reachable when the limit fits BIN_W
   assign w_clamp   = (64'(bus.i_bin) >= c_limit);
   assign w_bin_cap = w_clamp ? c_max[BIN_W-1:0] : bus.i_bin;
   assign w_accept  = bus.i_valid && r_ready && !w_cvt_busy;

   bin2bcd_serial #(
      .BIN_W  (BIN_W),
      .DIGITS (DIGITS)
   ) u_bin2bcd (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_start (w_accept),
      .i_bin   (w_bin_cap),
      .o_busy  (w_cvt_busy),
      .o_done  (w_cvt_last),
      .o_bcd   (w_bcd)
   );

   // Handshake sequencer; the display registers change only in DONE, all at once
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_ready <= 1'b1;
         r_done  <= 1'b0;
         r_ovf   <= 1'b0;
         r_disp  <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_state <= SHIFT;
                  r_ready <= 1'b0;
                  r_ovf   <= w_clamp;
               end
            end
            SHIFT: begin
               if (w_cvt_last) begin
                  r_state <= DONE;
               end
            end
            DONE: begin
               r_disp  <= w_bcd;
               r_done  <= 1'b1;
               r_ready <= 1'b1;
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

`ifdef FND_LEADING_ZERO_BLANK_EN
   logic w_zero_run;

   // Blank every zero digit above the most significant nonzero one; digit 0 stays
   always_comb begin
      w_code     = r_disp;
      w_zero_run = 1'b1;
      for (int i = DIGITS - 1; i > 0; i--) begin
         w_zero_run = w_zero_run && (r_disp[i] == 4'd0);
         if (w_zero_run) begin
            w_code[i] = BLANK_CODE;
         end
      end
   end
`else
   // Every digit shows its BCD value, leading zeros included
   always_comb begin
      w_code = r_disp;
   end
`endif

   assign w_wrap    = (r_presc == c_last_presc);
   assign w_idx_nxt = !w_wrap ? r_idx :
                      (r_idx == c_last_idx) ? '0 : (r_idx + 1'b1);

   // Scan: common and data are registered from the same index so they switch together
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_presc      <= '0;
         r_idx        <= '0;
         r_com        <= ~DIGITS'(1);
         r_digit_data <= 4'd0;
      end else begin
         r_presc      <= w_wrap ? '0 : (r_presc + 1'b1);
         r_idx        <= w_idx_nxt;
         r_com        <= ~(DIGITS'(1) << w_idx_nxt);
         r_digit_data <= w_code[w_idx_nxt];
      end
   end

   assign bus.o_ready      = r_ready;
   assign bus.o_done       = r_done;
   assign bus.o_ovf        = r_ovf;
   assign bus.o_com        = r_com;
   assign bus.o_digit_data = r_digit_data;

endmodule

`default_nettype wire

// File: tb/tb_fnd_scan_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_fnd_scan_ctrl
// Brief    : Scoreboard bench for fnd_scan_ctrl (BIN_W=14, DIGITS=4,
//            REFRESH_DIV=4). Honours FND_LEADING_ZERO_BLANK_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fnd_scan_ctrl;
   import fnd_pkg::*;

   localparam int BIN_W       = 14;
   localparam int DIGITS      = 4;
   localparam int REFRESH_DIV = 4;

   typedef struct {
      int val;
      bit ovf;
      int acc;
   } txn_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   n_pass  = 0;
   int   n_total = 0;

   txn_t sb[$];
   txn_t m_txn;
   int   m_presc  = 0;
   int   m_idx    = 0;
   int   exp_disp = 0;
   int   pend_val = 0;
   bit   pend     = 1'b0;

   fnd_scan_ctrl_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

   fnd_scan_ctrl #(
      .BIN_W       (BIN_W),
      .DIGITS      (DIGITS),
      .REFRESH_DIV (REFRESH_DIV)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
   endtask

   // Expected decoder code for digit idx of a displayed value
   function automatic logic [3:0] exp_code(input int val, input int idx);
      int p = 1;
      for (int j = 0; j < idx; j++) p = p * 10;
`ifdef FND_LEADING_ZERO_BLANK_EN
      if (idx != 0 && val < p) return 4'hF;
`endif
      return 4'((val / p) % 10);
   endfunction

   // Reference scan position
   always @(posedge clk) begin
      if (!rst_n) begin
         m_presc <= 0;
         m_idx   <= 0;
      end else if (m_presc == REFRESH_DIV - 1) begin
         m_presc <= 0;
         m_idx   <= (m_idx == DIGITS - 1) ? 0 : m_idx + 1;
      end else begin
         m_presc <= m_presc + 1;
      end
   end

   // Output monitor: scan checks every cycle, scoreboard pop on o_done
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
         exp_disp = 0;
         pend     = 1'b0;
      end else begin
         if (pend) begin
            exp_disp = pend_val;
            pend     = 1'b0;
         end
         check("com", 32'(bus.o_com), 32'(4'(~(4'b0001 << m_idx))));
         check("digit", 32'(bus.o_digit_data), 32'(exp_code(exp_disp, m_idx)));
         if (bus.o_done) begin
            if (sb.size() == 0) begin
               check("done_spurious", 32'(bus.o_done), 32'd0);
            end else begin
               m_txn = sb.pop_front();
               check("latency", 32'(cyc - m_txn.acc), 32'(BIN_W + 1));
               check("ovf", 32'(bus.o_ovf), 32'(m_txn.ovf));
               pend_val = m_txn.val;
               pend     = 1'b1;
            end
         end
      end
   end

   // Offer a value; returns just after the accepting edge. Returns accept cycle.
   task automatic send(input int v, input bit hold, output int acc);
      int t = 0;
      txn_t e;
      @(negedge clk);
      while (!bus.o_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!bus.o_ready) check("ready_timeout", 32'(bus.o_ready), 32'd1);
      bus.i_valid = 1'b1;
      bus.i_bin   = BIN_W'(v);
      @(posedge clk);
      #1;
      acc   = cyc;
      e.val = (v >= 10000) ? 9999 : v;
      e.ovf = (v >= 10000);
      e.acc = acc;
      sb.push_back(e);
      check("ready_low", 32'(bus.o_ready), 32'd0);
      if (!hold) bus.i_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      while (sb.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("idle_timeout", 32'(sb.size()), 32'd0);
      repeat (20) @(negedge clk);
   endtask

   initial begin
      int a1, a2, dummy;
      int vals[6] = '{1234, 16383, 7, 9999, 10000, 0};
      bus.i_valid = 1'b0;
      bus.i_bin   = '0;

      // Reset values
      repeat (2) @(negedge clk);
      check("rst_ready", 32'(bus.o_ready), 32'd1);
      check("rst_done", 32'(bus.o_done), 32'd0);
      check("rst_ovf", 32'(bus.o_ovf), 32'd0);
      check("rst_com", 32'(bus.o_com), 32'(4'b1110));
      check("rst_data", 32'(bus.o_digit_data), 32'd0);
      rst_n = 1'b1;

      // Idle scan with no input
      repeat (20) @(negedge clk);

      // Basic values, clamp and its boundary
      foreach (vals[i]) begin
         send(vals[i], 1'b0, dummy);
         wait_idle();
      end

      // Value offered during SHIFT must be ignored until ready returns
      send(4321, 1'b1, a1);
      bus.i_bin = BIN_W'(5678);
      send(5678, 1'b0, a2);
      check("accept_gap", 32'(a2 - a1), 32'(BIN_W + 2));
      wait_idle();

      // Blanking patterns
      send(40, 1'b0, dummy);
      wait_idle();
      send(305, 1'b0, dummy);
      wait_idle();

      // Asynchronous reset in the middle of a clamped conversion
      send(20000, 1'b0, dummy);
      repeat (5) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_ready", 32'(bus.o_ready), 32'd1);
      check("arst_done", 32'(bus.o_done), 32'd0);
      check("arst_ovf", 32'(bus.o_ovf), 32'd0);
      check("arst_com", 32'(bus.o_com), 32'(4'b1110));
      check("arst_data", 32'(bus.o_digit_data), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      check("arst_no_done", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
